// File: rtl/ksa_swap_fsm.sv
// RC4 key-scheduling swap loop over a 256-entry S memory through a request/finish handshake.
// The S memory must already hold the identity permutation before start_ksa is raised.
module ksa_swap_fsm #(
  parameter int KEY_LENGTH = 3,
  parameter int KEY_WIDTH  = 24
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [KEY_WIDTH-1:0] secret_key,
  input  logic                 start_ksa,
  output logic                 finish_ksa,
  output logic [7:0]           S_address,
  output logic [7:0]           S_data_out,
  input  logic [7:0]           S_data_in,
  output logic                 S_readWrite,
  output logic                 S_start_readWrite_op,
  input  logic                 S_finish_readWrite_op
);

  // state  | meaning
  // IDLE   | waiting for start_ksa
  // RD_*   | issue access (one-cycle start pulse)
  // WT_*   | hold access until finish
  // CALC_J | j += S[i] + key byte
  // NEXT_I | advance i or finish
  // DONE   | finish_ksa high until start_ksa drops
  typedef enum logic [3:0] {
    IDLE, RD_SI, WT_SI, CALC_J, RD_SJ, WT_SJ,
    WR_SI, WT_WI, WR_SJ, WT_WJ, NEXT_I, DONE
  } state_t;

  localparam int KIDX_W = (KEY_LENGTH > 1) ? $clog2(KEY_LENGTH) : 1;

  state_t r_state, w_next;
  logic [7:0]        r_i, r_j, r_si, r_sj;
  logic [KIDX_W-1:0] r_kidx;
  logic [7:0]        w_key_byte;

  // Key byte index tracks i mod KEY_LENGTH incrementally to avoid a divider.
  always_comb begin
    w_key_byte = 8'h00;
    for (int k = 0; k < KEY_LENGTH; k++)
      if (r_kidx == KIDX_W'(k)) w_key_byte = secret_key[KEY_WIDTH-1-8*k -: 8];
  end

  always_ff @(posedge clk) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_next;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_i    <= 8'h00;
      r_j    <= 8'h00;
      r_si   <= 8'h00;
      r_sj   <= 8'h00;
      r_kidx <= '0;
    end else begin
      case (r_state)
        IDLE: if (start_ksa) begin
          r_i    <= 8'h00;
          r_j    <= 8'h00;
          r_kidx <= '0;
        end
        WT_SI:  if (S_finish_readWrite_op) r_si <= S_data_in;
        CALC_J: r_j <= r_j + r_si + w_key_byte;
        WT_SJ:  if (S_finish_readWrite_op) r_sj <= S_data_in;
        NEXT_I: if (r_i != 8'hFF) begin
          r_i    <= r_i + 8'h01;
          r_kidx <= (r_kidx == KIDX_W'(KEY_LENGTH-1)) ? '0 : r_kidx + 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:   if (start_ksa) w_next = RD_SI;
      RD_SI:  w_next = WT_SI;
      WT_SI:  if (S_finish_readWrite_op) w_next = CALC_J;
      CALC_J: w_next = RD_SJ;
      RD_SJ:  w_next = WT_SJ;
      WT_SJ:  if (S_finish_readWrite_op) w_next = WR_SI;
      WR_SI:  w_next = WT_WI;
      WT_WI:  if (S_finish_readWrite_op) w_next = WR_SJ;
      WR_SJ:  w_next = WT_WJ;
      WT_WJ:  if (S_finish_readWrite_op) w_next = NEXT_I;
      NEXT_I: w_next = (r_i == 8'hFF) ? DONE : RD_SI;
      DONE:   if (!start_ksa) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_comb begin
    finish_ksa           = 1'b0;
    S_address            = 8'h00;
    S_data_out           = 8'h00;
    S_readWrite          = 1'b0;
    S_start_readWrite_op = 1'b0;
    case (r_state)
      RD_SI, WT_SI: begin
        S_address            = r_i;
        S_start_readWrite_op = (r_state == RD_SI);
      end
      RD_SJ, WT_SJ: begin
        S_address            = r_j;
        S_start_readWrite_op = (r_state == RD_SJ);
      end
      WR_SI, WT_WI: begin
        S_address            = r_i;
        S_data_out           = r_sj;
        S_readWrite          = 1'b1;
        S_start_readWrite_op = (r_state == WR_SI);
      end
      WR_SJ, WT_WJ: begin
        S_address            = r_j;
        S_data_out           = r_si;
        S_readWrite          = 1'b1;
        S_start_readWrite_op = (r_state == WR_SJ);
      end
      DONE: finish_ksa = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_ksa_swap_fsm.sv
// Directed bench for ksa_swap_fsm: behavioural S memory with optional finish delay,
// hand-computed write traces, software KSA reference and handshake timing.
module tb_ksa_swap_fsm;
  logic        clk = 1'b0;
  logic        reset;
  logic [23:0] secret_key;
  logic        start_ksa;
  logic        finish_ksa;
  logic [7:0]  S_address, S_data_out, S_data_in;
  logic        S_readWrite, S_start_readWrite_op, S_finish_readWrite_op;

  int n_cmp = 0;
  int n_bad = 0;

  logic [7:0] mem [256];
  logic [7:0] exp_s [256];
  logic [7:0] snap_s [256];
  logic       mem_init = 1'b0;
  int         fin_dly = 0;
  int         wcnt = 0;
  int         pulse_cnt = 0;
  int         stab_err = 0;
  logic       in_wait = 1'b0;
  logic [7:0] h_addr, h_data;
  logic       h_rw;
  logic [7:0] wr_addr [$];
  logic [7:0] wr_data [$];

  ksa_swap_fsm #(.KEY_LENGTH(3), .KEY_WIDTH(24)) dut (
    .clk(clk), .reset(reset), .secret_key(secret_key), .start_ksa(start_ksa),
    .finish_ksa(finish_ksa), .S_address(S_address), .S_data_out(S_data_out),
    .S_data_in(S_data_in), .S_readWrite(S_readWrite),
    .S_start_readWrite_op(S_start_readWrite_op),
    .S_finish_readWrite_op(S_finish_readWrite_op)
  );

  always #5 clk = ~clk;

  assign S_data_in = mem[S_address];
  assign S_finish_readWrite_op = (fin_dly == 0) ? 1'b1 : (wcnt == fin_dly);

  // Memory, finish-delay counter and access-stability monitor.
  always @(posedge clk) begin
    if (mem_init) begin
      for (int k = 0; k < 256; k++) mem[k] <= 8'(k);
    end else if (!reset && S_start_readWrite_op && S_readWrite) begin
      mem[S_address] <= S_data_out;
    end
    if (!reset && S_start_readWrite_op) begin
      pulse_cnt <= pulse_cnt + 1;
      if (S_readWrite) begin
        wr_addr.push_back(S_address);
        wr_data.push_back(S_data_out);
      end
    end
    if (reset) begin
      wcnt    <= 0;
      in_wait <= 1'b0;
    end else if (S_start_readWrite_op) begin
      wcnt    <= 1;
      if (in_wait) stab_err <= stab_err + 1;
      in_wait <= 1'b1;
      h_addr  <= S_address;
      h_data  <= S_data_out;
      h_rw    <= S_readWrite;
    end else begin
      if (wcnt != 0 && wcnt < fin_dly) wcnt <= wcnt + 1;
      else wcnt <= 0;
      if (in_wait) begin
        if (S_address !== h_addr || S_data_out !== h_data || S_readWrite !== h_rw)
          stab_err <= stab_err + 1;
        if (S_finish_readWrite_op) in_wait <= 1'b0;
      end
    end
  end

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    start_ksa = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic init_mem();
    @(negedge clk);
    mem_init = 1'b1;
    @(negedge clk);
    mem_init = 1'b0;
  endtask

  task automatic ksa_model(input logic [23:0] key);
    logic [7:0] j, t, kb;
    for (int k = 0; k < 256; k++) exp_s[k] = 8'(k);
    j = 8'h00;
    for (int i = 0; i < 256; i++) begin
      case (i % 3)
        0: kb = key[23:16];
        1: kb = key[15:8];
        default: kb = key[7:0];
      endcase
      j = j + exp_s[i] + kb;
      t = exp_s[i];
      exp_s[i] = exp_s[j];
      exp_s[j] = t;
    end
  endtask

  task automatic run_to_done(output int cyc, output bit ok);
    @(negedge clk);
    start_ksa = 1'b1;
    @(posedge clk);
    cyc = 0;
    ok = 1'b0;
    for (int n = 0; n < 30000; n++) begin
      @(negedge clk);
      cyc++;
      if (finish_ksa) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    do_reset();
    n_cmp++; if (finish_ksa !== 1'b0) begin n_bad++; $display("FAIL reset_finish got %0b want 0", finish_ksa); end
    n_cmp++; if (S_start_readWrite_op !== 1'b0) begin n_bad++; $display("FAIL reset_start got %0b want 0", S_start_readWrite_op); end
    n_cmp++; if (S_readWrite !== 1'b0) begin n_bad++; $display("FAIL reset_rw got %0b want 0", S_readWrite); end
    n_cmp++; if (S_address !== 8'h00) begin n_bad++; $display("FAIL reset_addr got %h want 00", S_address); end
    n_cmp++; if (S_data_out !== 8'h00) begin n_bad++; $display("FAIL reset_data got %h want 00", S_data_out); end
  endtask

  task automatic test_trace(input logic [23:0] key, input logic [7:0] ea [6], input logic [7:0] ed [6]);
    int cyc, base;
    bit ok;
    do_reset();
    init_mem();
    fin_dly = 0;
    secret_key = key;
    base = wr_addr.size();
    run_to_done(cyc, ok);
    n_cmp++; if (!ok) begin n_bad++; $display("FAIL trace_%h_timeout got no finish want finish", key); end
    n_cmp++; if (cyc != 2561) begin n_bad++; $display("FAIL trace_%h_latency got %0d want 2561", key, cyc); end
    for (int w = 0; w < 6; w++) begin
      n_cmp++;
      if (wr_addr.size() <= base + w || wr_addr[base+w] !== ea[w] || wr_data[base+w] !== ed[w]) begin
        n_bad++;
        if (wr_addr.size() <= base + w) $display("FAIL trace_%h_w%0d got missing write want %h<=%h", key, w, ea[w], ed[w]);
        else $display("FAIL trace_%h_w%0d got %h<=%h want %h<=%h", key, w, wr_addr[base+w], wr_data[base+w], ea[w], ed[w]);
      end
    end
    @(negedge clk);
    start_ksa = 1'b0;
  endtask

  task automatic test_full_run();
    int cyc, diff;
    bit ok;
    bit seen [256];
    int dup;
    do_reset();
    init_mem();
    fin_dly = 0;
    secret_key = 24'h1E4600;
    ksa_model(24'h1E4600);
    run_to_done(cyc, ok);
    n_cmp++; if (!ok || cyc != 2561) begin n_bad++; $display("FAIL full_latency got %0d (ok=%0b) want 2561", cyc, ok); end
    diff = 0;
    for (int k = 0; k < 256; k++) begin
      if (mem[k] !== exp_s[k]) diff++;
      snap_s[k] = exp_s[k];
      seen[k] = 1'b0;
    end
    n_cmp++; if (diff != 0) begin n_bad++; $display("FAIL full_s_contents got %0d differing bytes want 0", diff); end
    dup = 0;
    for (int k = 0; k < 256; k++) begin
      if (seen[mem[k]]) dup++;
      seen[mem[k]] = 1'b1;
    end
    n_cmp++; if (dup != 0) begin n_bad++; $display("FAIL full_permutation got %0d duplicates want 0", dup); end
  endtask

  task automatic test_handshake();
    int p0;
    logic [7:0] exp_j;
    p0 = pulse_cnt;
    repeat (20) @(negedge clk);
    n_cmp++; if (finish_ksa !== 1'b1) begin n_bad++; $display("FAIL hs_hold_finish got %0b want 1", finish_ksa); end
    n_cmp++; if (pulse_cnt != p0) begin n_bad++; $display("FAIL hs_hold_pulses got %0d want 0", pulse_cnt - p0); end
    start_ksa = 1'b0;
    @(negedge clk);
    n_cmp++; if (finish_ksa !== 1'b0) begin n_bad++; $display("FAIL hs_drop_finish got %0b want 0", finish_ksa); end
    exp_j = mem[0] + 8'h1E;
    start_ksa = 1'b1;
    @(negedge clk);
    n_cmp++; if (S_start_readWrite_op !== 1'b1 || S_readWrite !== 1'b0 || S_address !== 8'h00) begin
      n_bad++; $display("FAIL hs_restart_rd_si got start=%0b rw=%0b addr=%h want 1 0 00", S_start_readWrite_op, S_readWrite, S_address);
    end
    repeat (3) @(negedge clk);
    n_cmp++; if (S_start_readWrite_op !== 1'b1 || S_readWrite !== 1'b0 || S_address !== exp_j) begin
      n_bad++; $display("FAIL hs_restart_rd_sj got start=%0b rw=%0b addr=%h want 1 0 %h", S_start_readWrite_op, S_readWrite, S_address, exp_j);
    end
    do_reset();
  endtask

  task automatic test_delayed();
    int cyc, diff, p0, s0;
    bit ok;
    do_reset();
    init_mem();
    fin_dly = 3;
    secret_key = 24'h1E4600;
    p0 = pulse_cnt;
    s0 = stab_err;
    run_to_done(cyc, ok);
    n_cmp++; if (!ok) begin n_bad++; $display("FAIL dly_timeout got no finish want finish"); end
    diff = 0;
    for (int k = 0; k < 256; k++) if (mem[k] !== snap_s[k]) diff++;
    n_cmp++; if (diff != 0) begin n_bad++; $display("FAIL dly_s_contents got %0d differing bytes want 0", diff); end
    n_cmp++; if (pulse_cnt - p0 != 1024) begin n_bad++; $display("FAIL dly_pulse_count got %0d want 1024", pulse_cnt - p0); end
    n_cmp++; if (stab_err != s0) begin n_bad++; $display("FAIL dly_stability got %0d violations want 0", stab_err - s0); end
    @(negedge clk);
    start_ksa = 1'b0;
    fin_dly = 0;
    @(negedge clk);
  endtask

  task automatic test_reset_midrun();
    int base, p0;
    bit found;
    do_reset();
    init_mem();
    fin_dly = 0;
    secret_key = 24'h000249;
    base = wr_addr.size();
    @(negedge clk);
    start_ksa = 1'b1;
    found = 1'b0;
    for (int n = 0; n < 2000; n++) begin
      @(negedge clk);
      if (wr_addr.size() >= base + 80 && S_start_readWrite_op && !S_readWrite) begin
        found = 1'b1;
        break;
      end
    end
    n_cmp++; if (!found || S_address !== 8'd40) begin n_bad++; $display("FAIL mid_reach_i40 got found=%0b addr=%0d want 1 40", found, S_address); end
    reset = 1'b1;
    start_ksa = 1'b0;
    @(negedge clk);
    n_cmp++; if (finish_ksa !== 1'b0 || S_start_readWrite_op !== 1'b0 || S_readWrite !== 1'b0 ||
                 S_address !== 8'h00 || S_data_out !== 8'h00) begin
      n_bad++; $display("FAIL mid_outputs got fin=%0b st=%0b rw=%0b a=%h d=%h want all 0",
                        finish_ksa, S_start_readWrite_op, S_readWrite, S_address, S_data_out);
    end
    reset = 1'b0;
    p0 = pulse_cnt;
    repeat (20) @(negedge clk);
    n_cmp++; if (pulse_cnt != p0) begin n_bad++; $display("FAIL mid_no_pulses got %0d want 0", pulse_cnt - p0); end
  endtask

  initial begin
    logic [7:0] ea0 [6] = '{8'h00, 8'h00, 8'h01, 8'h01, 8'h02, 8'h03};
    logic [7:0] ed0 [6] = '{8'h00, 8'h00, 8'h01, 8'h01, 8'h03, 8'h02};
    logic [7:0] ea1 [6] = '{8'h00, 8'h00, 8'h01, 8'h03, 8'h02, 8'h4E};
    logic [7:0] ed1 [6] = '{8'h00, 8'h00, 8'h03, 8'h01, 8'h4E, 8'h02};
    reset = 1'b1;
    start_ksa = 1'b0;
    secret_key = 24'h000000;
    test_reset();
    test_trace(24'h000000, ea0, ed0);
    test_trace(24'h000249, ea1, ed1);
    test_full_run();
    test_handshake();
    test_delayed();
    test_reset_midrun();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
